// File: rtl/sram_dma_reader_if.sv
// Bundles the sram_dma_reader configuration/status, SRAM DMA read port and output stream.
//   master: the DMA reader (drives status, dma_rd_en/dma_rd_addr, out_valid/out_data/out_last)
//   slave : the environment (drives cfg_*, dma_rdata, out_ready)
interface sram_dma_reader_if #(
  parameter int unsigned LEN_BITS = 16
);
  logic                cfg_start;
  logic [31:0]         cfg_src_addr;
  logic [LEN_BITS-1:0] cfg_len_words;
  logic                busy;
  logic                done;
  logic                err;
  logic                dma_rd_en;
  logic [31:0]         dma_rd_addr;
  logic [31:0]         dma_rdata;
  logic                out_valid;
  logic [31:0]         out_data;
  logic                out_last;
  logic                out_ready;

  modport master (
    input  cfg_start, cfg_src_addr, cfg_len_words, dma_rdata, out_ready,
    output busy, done, err, dma_rd_en, dma_rd_addr, out_valid, out_data, out_last
  );

  modport slave (
    output cfg_start, cfg_src_addr, cfg_len_words, dma_rdata, out_ready,
    input  busy, done, err, dma_rd_en, dma_rd_addr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/sram_dma_reader.sv
// DMA reader: fetches cfg_len_words 32-bit words starting at cfg_src_addr from the SRAM DMA
// read port (combinational rdata) and streams them out through a 2-entry FIFO.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : sram_dma_reader_if.master (cfg/status, SRAM DMA port, valid/ready stream)
// LEN_BITS must match the LEN_BITS of the connected interface.
module sram_dma_reader #(
  parameter int unsigned MEM_BYTES = 16384,
  parameter int unsigned LEN_BITS  = 16
) (
  input logic               clk,
  input logic               rst,
  sram_dma_reader_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e              state_q;
  logic [31:0]         cur_addr_q;
  logic [LEN_BITS-1:0] remaining_q;
  logic                err_q;

  logic [31:0] fifo_data_q [2];
  logic [1:0]  fifo_last_q;
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;

  logic        rd_en;
  logic        pop;
  logic        last_word;
  logic        cfg_bad;
  logic [33:0] end_addr;

  // 34-bit end address so a large source address plus length cannot wrap past the check.
  assign end_addr  = {2'b00, bus.cfg_src_addr} + (34'(bus.cfg_len_words) << 2);
  assign cfg_bad   = (bus.cfg_src_addr[1:0] != 2'b00) || (end_addr > 34'(MEM_BYTES));

  // Read enable uses only registered state, so out_ready never reaches the SRAM port.
  assign rd_en     = (state_q == StRead) && (count_q != 2'd2);
  assign pop       = (count_q != 2'd0) && bus.out_ready;
  assign last_word = (remaining_q == LEN_BITS'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      cur_addr_q     <= '0;
      remaining_q    <= '0;
      err_q          <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q    <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= '0;
    end else begin
      if (rd_en) begin
        fifo_data_q[wr_ptr_q] <= bus.dma_rdata;
        fifo_last_q[wr_ptr_q] <= last_word;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, rd_en} - {1'b0, pop};

      unique case (state_q)
        StIdle: begin
          if (bus.cfg_start) begin
            cur_addr_q  <= bus.cfg_src_addr;
            remaining_q <= bus.cfg_len_words;
            err_q       <= 1'b0;
            if (bus.cfg_len_words == '0) begin
              state_q <= StDone;
            end else if (cfg_bad) begin
              err_q   <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StRead;
            end
          end
        end
        StRead: begin
          if (rd_en) begin
            cur_addr_q  <= cur_addr_q + 32'd4;
            remaining_q <= remaining_q - LEN_BITS'(1);
            if (last_word) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          // The last-flagged entry is always the youngest, so popping the sole entry ends it.
          if (pop && (count_q == 2'd1)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = (state_q == StDone);
  assign bus.err         = err_q;
  assign bus.dma_rd_en   = rd_en;
  assign bus.dma_rd_addr = rd_en ? cur_addr_q : 32'd0;
  assign bus.out_valid   = (count_q != 2'd0);
  assign bus.out_data    = fifo_data_q[rd_ptr_q];
  assign bus.out_last    = (count_q != 2'd0) && fifo_last_q[rd_ptr_q];

endmodule
